// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: one pattern table used by both the
// forward hex-to-segment decoder and the reverse segment reader.
package sevenseg_pkg;

    // Active-low segment pattern, bit order {g,f,e,d,c,b,a}.
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'h40;
    localparam seg_t SEG_1     = 7'h79;
    localparam seg_t SEG_2     = 7'h24;
    localparam seg_t SEG_3     = 7'h30;
    localparam seg_t SEG_4     = 7'h19;
    localparam seg_t SEG_5     = 7'h12;
    localparam seg_t SEG_6     = 7'h02;
    localparam seg_t SEG_7     = 7'h78;
    localparam seg_t SEG_8     = 7'h00;
    localparam seg_t SEG_9     = 7'h10;
    localparam seg_t SEG_A     = 7'h08;
    localparam seg_t SEG_B     = 7'h03;
    localparam seg_t SEG_C     = 7'h46;
    localparam seg_t SEG_D     = 7'h21;
    localparam seg_t SEG_E     = 7'h06;
    localparam seg_t SEG_F     = 7'h0E;
    localparam seg_t SEG_BLANK = 7'h7F;

    // Candidate tracker states of the reader.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        TRACK = 2'd1,
        HELD  = 2'd2
    } rd_state_t;

endpackage

// File: rtl/sevenseg_pattern_decode.sv
// Combinational reverse decode: segment pattern -> nibble plus blank/error flags.
module sevenseg_pattern_decode
    import sevenseg_pkg::*;
(
    input  seg_t       seg_i,
    output logic [3:0] nibble_o,
    output logic       blank_o,
    output logic       err_o
);

    // Map canonical glyphs back to their value; anything unknown is flagged.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        nibble_o = 4'h0;
        blank_o  = 1'b0;
        err_o    = 1'b0;
        case (seg_i)
            SEG_0:     nibble_o = 4'h0;
            SEG_1:     nibble_o = 4'h1;
            SEG_2:     nibble_o = 4'h2;
            SEG_3:     nibble_o = 4'h3;
            SEG_4:     nibble_o = 4'h4;
            SEG_5:     nibble_o = 4'h5;
            SEG_6:     nibble_o = 4'h6;
            SEG_7:     nibble_o = 4'h7;
            SEG_8:     nibble_o = 4'h8;
            SEG_9:     nibble_o = 4'h9;
            SEG_A:     nibble_o = 4'hA;
            SEG_B:     nibble_o = 4'hB;
            SEG_C:     nibble_o = 4'hC;
            SEG_D:     nibble_o = 4'hD;
            SEG_E:     nibble_o = 4'hE;
            SEG_F:     nibble_o = 4'hF;
            SEG_BLANK: blank_o  = 1'b1;
            default:   err_o    = 1'b1;
        endcase
    end

endmodule

// File: rtl/sevenseg_reader.sv
// Recovers hex digits from a scanned active-low seven-segment bus. A sample
// must repeat STABLE_CNT times before it is committed to the digit bank.
module sevenseg_reader
    import sevenseg_pkg::*;
#(
    parameter  int NUM_DIGITS = 6,
    parameter  int STABLE_CNT = 3,
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [IDX_W-1:0]        in_digit,
    input  logic [6:0]              in_segments,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic [NUM_DIGITS-1:0]   err,
    output logic                    upd_valid,
    output logic [IDX_W-1:0]        upd_digit
);

    localparam logic [IDX_W:0] DIGIT_LIM  = (IDX_W + 1)'(NUM_DIGITS);
    localparam logic [3:0]     STABLE_LIM = 4'(STABLE_CNT);

    // Stage 1 state: candidate sample and its run length.
    rd_state_t        state_q, state_d;
    logic [IDX_W-1:0] cand_digit_q, cand_digit_d;
    seg_t             cand_seg_q, cand_seg_d;
    logic [3:0]       count_q, count_d;
    logic             commit_q, commit_d;

    // Stage 2 state: the per-digit register bank.
    logic [NUM_DIGITS-1:0][3:0] value_q;
    logic [NUM_DIGITS-1:0]      blank_q;
    logic [NUM_DIGITS-1:0]      err_q;
    logic                       upd_valid_q;
    logic [IDX_W-1:0]           upd_digit_q;

    logic       accepted;
    logic       same_as_cand;
    logic [3:0] dec_nibble;
    logic       dec_blank;
    logic       dec_err;

    // Out-of-range digit indices are invisible to the tracker.
    assign accepted     = in_valid && ({1'b0, in_digit} < DIGIT_LIM);
    assign same_as_cand = (in_digit == cand_digit_q) && (in_segments == cand_seg_q);

    // Candidate tracker: count identical accepted samples, fire commit once per run.
    always_comb begin
        state_d      = state_q;
        cand_digit_d = cand_digit_q;
        cand_seg_d   = cand_seg_q;
        count_d      = count_q;
        commit_d     = 1'b0;
        if (accepted) begin
            if ((state_q != EMPTY) && same_as_cand) begin
                // HELD absorbs repeats; only TRACK advances towards a commit.
                if (state_q == TRACK) begin
                    count_d = count_q + 4'd1;
                    if (count_d == STABLE_LIM) begin
                        state_d  = HELD;
                        commit_d = 1'b1;
                    end
                end
            end else begin
                cand_digit_d = in_digit;
                cand_seg_d   = in_segments;
                count_d      = 4'd1;
                if (STABLE_LIM == 4'd1) begin
                    state_d  = HELD;
                    commit_d = 1'b1;
                end else begin
                    state_d = TRACK;
                end
            end
        end
    end

    // Stage 1 registers; reset discards any partial candidate and pending commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            cand_digit_q <= '0;
            cand_seg_q   <= SEG_BLANK;
            count_q      <= 4'd0;
            commit_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q      <= state_d;
            cand_digit_q <= cand_digit_d;
            cand_seg_q   <= cand_seg_d;
            count_q      <= count_d;
            commit_q     <= commit_d;
        end
    end

    // The candidate registers still hold the committed sample during the commit cycle.
    sevenseg_pattern_decode u_decode (
        .seg_i    (cand_seg_q),
        .nibble_o (dec_nibble),
        .blank_o  (dec_blank),
        .err_o    (dec_err)
    );

    // Digit bank write: only the committed digit changes, plus a one-cycle update pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the bank is small and its reset state is observable, so it is reset explicitly.
            value_q     <= '0;
            blank_q     <= '1;
            err_q       <= '0;
            upd_valid_q <= 1'b0;
            upd_digit_q <= '0;
        end else begin
            upd_valid_q <= commit_q;
            if (commit_q) begin
                value_q[cand_digit_q] <= dec_nibble;
                blank_q[cand_digit_q] <= dec_blank;
                err_q[cand_digit_q]   <= dec_err;
                upd_digit_q           <= cand_digit_q;
            end
        end
    end

    assign value     = value_q;
    assign blank     = blank_q;
    assign err       = err_q;
    assign upd_valid = upd_valid_q;
    assign upd_digit = upd_digit_q;

endmodule

// File: tb/tb_sevenseg_reader.sv
// Scoreboard bench for sevenseg_reader: the driver predicts commits from the
// run-length rule and a reference glyph table; a monitor checks every pulse.
module tb_sevenseg_reader;

    localparam int ND    = 6;
    localparam int SC    = 3;
    localparam int IDX_W = (ND > 1) ? $clog2(ND) : 1;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic [IDX_W-1:0]    in_digit;
    logic [6:0]          in_segments;
    logic [4*ND-1:0]     value;
    logic [ND-1:0]       blank;
    logic [ND-1:0]       err;
    logic                upd_valid;
    logic [IDX_W-1:0]    upd_digit;

    sevenseg_reader #(.NUM_DIGITS(ND), .STABLE_CNT(SC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_digit    (in_digit),
        .in_segments (in_segments),
        .value       (value),
        .blank       (blank),
        .err         (err),
        .upd_valid   (upd_valid),
        .upd_digit   (upd_digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference glyph table, index = hex value.
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        int         d;
        logic [3:0] nib;
        logic       bl;
        logic       er;
        int         due;
    } exp_t;

    exp_t q[$];

    // Expected digit bank contents.
    logic [3:0] bank_val [ND];
    logic       bank_bl  [ND];
    logic       bank_er  [ND];

    // Run-length model of the input stream.
    bit         have_last;
    int         last_d;
    logic [6:0] last_s;
    int         run_len;

    function automatic void ref_decode(input logic [6:0] s, output logic [3:0] nib,
                                       output logic bl, output logic er);
        nib = 4'h0;
        bl  = (s == 7'h7F);
        er  = !bl;
        for (int k = 0; k < 16; k++) begin
            if (glyph[k] == s) begin
                nib = 4'(k);
                er  = 1'b0;
            end
        end
    endfunction

    function automatic void model_reset();
        have_last = 1'b0;
        run_len   = 0;
        last_d    = 0;
        last_s    = 7'h7F;
        q.delete();
        for (int i = 0; i < ND; i++) begin
            bank_val[i] = 4'h0;
            bank_bl[i]  = 1'b1;
            bank_er[i]  = 1'b0;
        end
    endfunction

    // Drive one cycle of input and predict any commit it causes.
    task automatic drive(input bit v, input int d, input logic [6:0] s);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid    = v;
        in_digit    = IDX_W'(d);
        in_segments = s;
        if (v && d < ND) begin
            if (have_last && d == last_d && s == last_s) begin
                run_len++;
            end else begin
                have_last = 1'b1;
                last_d    = d;
                last_s    = s;
                run_len   = 1;
            end
            if (run_len == SC) begin
                e.d   = d;
                ref_decode(s, e.nib, e.bl, e.er);
                e.due = cyc + 2;
                q.push_back(e);
            end
        end
    endtask

    task automatic repeat_sample(input int n, input int d, input logic [6:0] s);
        for (int i = 0; i < n; i++) drive(1'b1, d, s);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    bit mon_en = 1'b0;

    // Monitor: match every update pulse against the scoreboard, then compare the full bank.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            while (q.size() > 0 && q[0].due < cyc) begin
                check("missed_update_digit", 32'(q[0].d), 32'hFFFF_FFFF);
                void'(q.pop_front());
            end
            if (upd_valid) begin
                if (q.size() == 0 || q[0].due != cyc) begin
                    check("unexpected_update", 32'(upd_digit), 32'hFFFF_FFFF);
                end else begin
                    check("upd_digit", 32'(upd_digit), 32'(q[0].d));
                    bank_val[q[0].d] = q[0].nib;
                    bank_bl[q[0].d]  = q[0].bl;
                    bank_er[q[0].d]  = q[0].er;
                    void'(q.pop_front());
                end
            end
            for (int i = 0; i < ND; i++) begin
                if (value[4*i +: 4] !== bank_val[i] || blank[i] !== bank_bl[i] || err[i] !== bank_er[i]) begin
                    check($sformatf("bank_digit%0d", i),
                          {26'd0, err[i], blank[i], value[4*i +: 4]},
                          {26'd0, bank_er[i], bank_bl[i], bank_val[i]});
                end
            end
        end
    end

    logic [6:0] rs;
    int         rd;

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_digit    = '0;
        in_segments = 7'h7F;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state.
        @(negedge clk);
        check("reset_value", 32'(value), 32'h0);
        check("reset_blank", 32'(blank), 32'h3F);
        check("reset_err", 32'(err), 32'h0);
        check("reset_upd_valid", 32'(upd_valid), 32'h0);
        check("reset_upd_digit", 32'(upd_digit), 32'h0);
        mon_en = 1'b1;

        // Digit 2 shows '2'; a fourth repeat must not recommit.
        repeat_sample(4, 2, 7'h24);
        drive(1'b0, 0, 7'h7F);
        repeat (3) drive(1'b0, 0, 7'h7F);
        check("d2_value", 32'(value[11:8]), 32'h2);
        check("d2_blank", 32'(blank[2]), 32'h0);

        // Interrupted run on digit 1: the lone '4' never commits.
        drive(1'b1, 1, 7'h30);
        drive(1'b1, 1, 7'h30);
        drive(1'b1, 1, 7'h19);
        repeat_sample(3, 1, 7'h30);
        repeat (3) drive(1'b0, 0, 7'h7F);
        check("d1_value", 32'(value[7:4]), 32'h3);

        // Non-canonical pattern on digit 0, then 'F' with idle gaps.
        repeat_sample(3, 0, 7'h55);
        repeat (3) drive(1'b0, 0, 7'h7F);
        check("d0_err", 32'(err[0]), 32'h1);
        check("d0_err_value", 32'(value[3:0]), 32'h0);
        check("d0_err_blank", 32'(blank[0]), 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 0, 7'h0E);
            drive(1'b0, 0, 7'h0E);
            drive(1'b0, 3, 7'h11);
        end
        repeat (3) drive(1'b0, 0, 7'h7F);
        check("d0_value_f", 32'(value[3:0]), 32'hF);
        check("d0_err_clear", 32'(err[0]), 32'h0);

        // Digit 5: 'F' then blank.
        repeat_sample(3, 5, 7'h0E);
        repeat (3) drive(1'b0, 0, 7'h7F);
        check("d5_value_f", 32'(value[23:20]), 32'hF);
        repeat_sample(3, 5, 7'h7F);
        repeat (3) drive(1'b0, 0, 7'h7F);
        check("d5_blank", 32'(blank[5]), 32'h1);
        check("d5_value_0", 32'(value[23:20]), 32'h0);

        // Out-of-range index is ignored; reset discards a partial run on digit 3.
        repeat_sample(5, 7, 7'h40);
        repeat_sample(2, 3, 7'h00);
        do_reset();
        drive(1'b1, 3, 7'h00);
        repeat (3) drive(1'b0, 0, 7'h7F);
        check("d3_after_reset", 32'(value[15:12]), 32'h0);
        repeat_sample(2, 3, 7'h00);
        repeat (3) drive(1'b0, 0, 7'h7F);
        check("d3_value_8", 32'(value[15:12]), 32'h8);

        // Randomized phase with biased repeats and occasional resets.
        rd = 0;
        rs = 7'h40;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 9) >= 6) begin
                    rd = $urandom_range(0, (1 << IDX_W) - 1);
                    case ($urandom_range(0, 9))
                        7:       rs = 7'h7F;
                        8, 9:    rs = 7'($urandom);
                        default: rs = glyph[$urandom_range(0, 15)];
                    endcase
                end
                drive($urandom_range(0, 3) != 0, rd, rs);
            end
        end
        repeat (4) drive(1'b0, 0, 7'h7F);
        check("scoreboard_drained", 32'(q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sevenseg_reader.md
Name: sevenseg_reader

Overview:
- Reverse path of the hex-to-segment decoder: recovers hex digits from active-low seven-segment patterns, ordered {g,f,e,d,c,b,a}.
- Takes a time-multiplexed stream of (digit index, segment pattern) samples from a scanned HEX display bus or a loopback tap.
- Filters glitches by requiring repeated identical samples, then decodes each pattern back to a nibble.
- Keeps a per-digit register bank so the calculator bench and self-check logic can read the displayed value as hex.

Parameters:
- NUM_DIGITS, 6: number of display digits tracked (1..8).
- STABLE_CNT, 3: consecutive identical valid samples needed before commit (1..15).
- IDX_W, max(1,$clog2(NUM_DIGITS)): digit index width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_digit/in_segments valid this cycle.
- in_digit  in  IDX_W  digit index of sample.
- in_segments  in  7  active-low pattern {g,f,e,d,c,b,a}.
- value  out  4*NUM_DIGITS  decoded nibbles; digit i at [4i+3:4i].
- blank  out  NUM_DIGITS  digit i last committed as all-off (7'h7F).
- err  out  NUM_DIGITS  digit i last committed as non-canonical pattern.
- upd_valid  out  1  one-cycle pulse when a digit register is written.
- upd_digit  out  IDX_W  index written when upd_valid=1.

Behaviour:
- Reset (async assert, sync release):
  - value=0, blank=all ones, err=0, upd_valid=0, upd_digit=0.
  - Candidate invalid, count=0, committed=0.
- Accepted sample: in_valid=1 and in_digit<NUM_DIGITS.
  - Samples with in_digit>=NUM_DIGITS are ignored entirely: no effect on candidate, count or outputs.
- Stage 1, candidate tracker; FSM states EMPTY, TRACK, HELD:
  - EMPTY: accepted sample -> candidate={digit,seg}, count=1. If STABLE_CNT=1, go HELD and fire commit; else go TRACK.
  - TRACK: accepted sample equal to candidate -> count+1. When count reaches STABLE_CNT, go HELD and fire commit.
  - TRACK: accepted sample that differs -> load new candidate, count=1, stay TRACK. With STABLE_CNT=1, HELD and commit instead.
  - HELD: identical accepted samples are absorbed, with no recommit.
  - HELD: a differing sample -> load new candidate, count=1, go TRACK (or commit at once if STABLE_CNT=1).
  - Cycles with in_valid=0 hold state and count; gaps do not break stability.
- Stage 2, commit register:
  - Commit fires on the edge that accepts the STABLE_CNT-th identical sample.
  - On the next edge, the digit register is written and upd_valid=1, upd_digit=index for exactly one cycle.
  - Latency: 1 cycle from the final qualifying sample edge to visible outputs.
- Decode rules:
  - Canonical patterns map to 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).
    - Write nibble; blank[i]=0, err[i]=0.
  - 7'h7F: nibble=0, blank[i]=1, err[i]=0.
  - Any other pattern: nibble=0, blank[i]=0, err[i]=1.
- Only digit i's fields change on commit; all other digits hold.
- Back-to-back commits to different digits are allowed. With STABLE_CNT=1, every differing accepted sample produces a pulse on consecutive cycles.
- Reset mid-count discards the partial candidate. Reset coincident with a pending commit wins: no write, no pulse.

Decomposition:
- sevenseg_pkg holds:
  - localparams SEG_0..SEG_F and SEG_BLANK (7'h7F).
  - typedef seg_t (logic [6:0]).
  - typedef enum rd_state_t {EMPTY, TRACK, HELD}.
  - The same constants drive the existing forward decoder, so both directions share one table.
- One sub-module, sevenseg_pattern_decode:
  - Combinational seg_t -> {nibble[3:0], is_blank, is_err}.
  - Instantiated in stage 2.

Test Plan (NUM_DIGITS=6, STABLE_CNT=3):
1. Release rst_n -> value=0, blank=6'b111111, err=0, upd_valid=0.
2. Digit 2, seg 7'h24, three valid cycles -> next cycle upd_valid=1, upd_digit=2, value[11:8]=2, blank[2]=0. Fourth identical sample -> no pulse.
3. Digit 1: 7'h30, 7'h30, 7'h19, 7'h30, 7'h30, 7'h30 -> single pulse after the last sample; value[7:4]=3; 4 never written.
4. Digit 0, 7'h55 ×3 -> err[0]=1, value[3:0]=0, blank[0]=0. Then 7'h0E ×3 with in_valid=0 gaps between samples -> value[3:0]=F, err[0]=0.
5. Digit 5: 7'h0E ×3, then 7'h7F ×3 -> after first pulse value[23:20]=F; after second blank[5]=1, value[23:20]=0.
6. in_digit=7 samples ×5 -> no change. Digit 3, two 7'h00 samples, pulse rst_n low, then one 7'h00 -> no update; two more 7'h00 -> value[15:12]=8.
